// File: rtl/pe_relay_pkg.sv
// Shared defaults for the PE relay FIFO block.
// Holds the default channel widths, FIFO depth and transfer-counter width.
// The top module and the per-channel sub-module both import these values.
package pe_relay_pkg;

  localparam int EAST_WIDTH_DEF  = 130;
  localparam int NORTH_WIDTH_DEF = 164;
  localparam int FIFO_DEPTH_DEF  = 4;   // power of two, >= 2
  localparam int CNT_WIDTH_DEF   = 16;

endpackage

// File: rtl/pe_relay_chan.sv
// One relay channel: a register-based FIFO with an occupancy level and an
// output-transfer counter.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   ap_start_i            accept enable (gates pushes only)
//   flush_i               synchronous clear of the stored words
//   in_data_i/in_valid_i/in_ready_o     upstream side
//   out_data_o/out_valid_o/out_ready_i  downstream side
//   level_o               current occupancy, 0..DEPTH
//   xfer_cnt_o            number of output transfers, wraps
//
// Handshake: a word moves on a side in every cycle where valid and ready are
// both high on that side. valid never depends on ready. Once out_valid_o is
// high, out_data_o holds the head word unchanged until it is taken.
// in_ready_o is low when full even if a pop happens in the same cycle, and
// both sides are held off while reset is high.
module pe_relay_chan
  import pe_relay_pkg::*;
#(
  parameter int WIDTH = EAST_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W = CNT_WIDTH_DEF,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ap_start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [LVL_W-1:0] level_o,
  output logic [CNT_W-1:0] xfer_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, empty, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  // Gating with reset means no handshake can complete in a reset cycle.
  assign in_ready_o  = !reset && ap_start_i && !full && !flush_i;
  assign out_valid_o = !reset && !empty;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  assign out_data_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign xfer_cnt_o = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    // A pop in the flush cycle is a real transfer and is counted.
    if (pop) cnt_d = cnt_q + CNT_W'(1);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: rtl/pe_relay_fifo.sv
// Two independent relay FIFOs (east and north) sharing clock, reset, accept
// enable and flush.
//
// Ports
//   clk, reset                    clock; synchronous active-high reset
//   ap_start                      accept enable for both channels
//   flush                         synchronous clear of both FIFOs
//   in_from_east/in_east_valid/in_east_ready      east input
//   out_to_east/out_east_valid/out_east_ready     east output
//   in_from_north/in_north_valid/in_north_ready   north input
//   out_to_north/out_north_valid/out_north_ready  north output
//   east_level, north_level       current occupancy per channel
//   east_xfer_cnt, north_xfer_cnt output transfer counts per channel
//
// Handshake: a word moves on a side in every cycle where valid and ready are
// both high on that side. valid never depends on ready. Once an output valid
// is high, its data holds the head word unchanged until the word is taken.
module pe_relay_fifo
  import pe_relay_pkg::*;
#(
  parameter int EAST_WIDTH  = EAST_WIDTH_DEF,
  parameter int NORTH_WIDTH = NORTH_WIDTH_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ap_start,
  input  logic                   flush,
  input  logic [EAST_WIDTH-1:0]  in_from_east,
  input  logic                   in_east_valid,
  output logic                   in_east_ready,
  output logic [EAST_WIDTH-1:0]  out_to_east,
  output logic                   out_east_valid,
  input  logic                   out_east_ready,
  input  logic [NORTH_WIDTH-1:0] in_from_north,
  input  logic                   in_north_valid,
  output logic                   in_north_ready,
  output logic [NORTH_WIDTH-1:0] out_to_north,
  output logic                   out_north_valid,
  input  logic                   out_north_ready,
  output logic [LVL_W-1:0]       east_level,
  output logic [LVL_W-1:0]       north_level,
  output logic [CNT_WIDTH-1:0]   east_xfer_cnt,
  output logic [CNT_WIDTH-1:0]   north_xfer_cnt
);

  pe_relay_chan #(
    .WIDTH (EAST_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_WIDTH)
  ) u_east (
    .clk         (clk),
    .reset       (reset),
    .ap_start_i  (ap_start),
    .flush_i     (flush),
    .in_data_i   (in_from_east),
    .in_valid_i  (in_east_valid),
    .in_ready_o  (in_east_ready),
    .out_data_o  (out_to_east),
    .out_valid_o (out_east_valid),
    .out_ready_i (out_east_ready),
    .level_o     (east_level),
    .xfer_cnt_o  (east_xfer_cnt)
  );

  pe_relay_chan #(
    .WIDTH (NORTH_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_WIDTH)
  ) u_north (
    .clk         (clk),
    .reset       (reset),
    .ap_start_i  (ap_start),
    .flush_i     (flush),
    .in_data_i   (in_from_north),
    .in_valid_i  (in_north_valid),
    .in_ready_o  (in_north_ready),
    .out_data_o  (out_to_north),
    .out_valid_o (out_north_valid),
    .out_ready_i (out_north_ready),
    .level_o     (north_level),
    .xfer_cnt_o  (north_xfer_cnt)
  );

endmodule

// File: tb/tb_pe_relay_fifo.sv
// Bench for pe_relay_fifo: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_pe_relay_fifo;

  localparam int EW    = 130;
  localparam int NW    = 164;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam logic [NW-1:0] EMASK = {{(NW-EW){1'b0}}, {EW{1'b1}}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ap_start, flush;
  logic [1:0]    in_valid, out_ready;
  logic [NW-1:0] in_data [2];

  logic [1:0]    act_rdy, act_vld;
  logic [NW-1:0] act_data [2];
  logic [LW-1:0] act_lvl [2];
  logic [CW-1:0] act_cnt [2];
  logic [EW-1:0] out_east_w;
  logic [NW-1:0] out_north_w;

  assign act_data[0] = {{(NW-EW){1'b0}}, out_east_w};
  assign act_data[1] = out_north_w;

  pe_relay_fifo #(
    .EAST_WIDTH  (EW),
    .NORTH_WIDTH (NW),
    .FIFO_DEPTH  (DEPTH),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk             (clk),
    .reset           (rst),
    .ap_start        (ap_start),
    .flush           (flush),
    .in_from_east    (in_data[0][EW-1:0]),
    .in_east_valid   (in_valid[0]),
    .in_east_ready   (act_rdy[0]),
    .out_to_east     (out_east_w),
    .out_east_valid  (act_vld[0]),
    .out_east_ready  (out_ready[0]),
    .in_from_north   (in_data[1]),
    .in_north_valid  (in_valid[1]),
    .in_north_ready  (act_rdy[1]),
    .out_to_north    (out_north_w),
    .out_north_valid (act_vld[1]),
    .out_north_ready (out_ready[1]),
    .east_level      (act_lvl[0]),
    .north_level     (act_lvl[1]),
    .east_xfer_cnt   (act_cnt[0]),
    .north_xfer_cnt  (act_cnt[1])
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [NW-1:0] exp_q [2][$];
  logic [CW-1:0] m_cnt [2];
  logic          e_rdy [2];
  logic          e_vld [2];
  logic          chk_en   = 1'b0;
  logic          prev_rst = 1'b0;

  // Compare at the falling edge, then advance the model to what the
  // following rising edge must produce.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 2; c++) begin
        e_rdy[c] = !rst && ap_start && !flush && (exp_q[c].size() < DEPTH);
        e_vld[c] = !rst && (exp_q[c].size() > 0);
        check($sformatf("ch%0d_in_ready", c), NW'(act_rdy[c]), NW'(e_rdy[c]));
        check($sformatf("ch%0d_out_valid", c), NW'(act_vld[c]), NW'(e_vld[c]));
        check($sformatf("ch%0d_level", c), NW'(act_lvl[c]), NW'(exp_q[c].size()));
        check($sformatf("ch%0d_xfer_cnt", c), NW'(act_cnt[c]), NW'(m_cnt[c]));
        if (e_vld[c]) check($sformatf("ch%0d_out_data", c), act_data[c], exp_q[c][0]);
        if (prev_rst) check($sformatf("ch%0d_data_after_reset", c), act_data[c], '0);
      end
      for (int c = 0; c < 2; c++) begin
        if (rst) begin
          exp_q[c].delete();
          m_cnt[c] = '0;
        end else begin
          if (e_vld[c] && out_ready[c]) begin
            void'(exp_q[c].pop_front());
            m_cnt[c] = m_cnt[c] + 1'b1;
          end
          if (flush) exp_q[c].delete();
          else if (e_rdy[c] && in_valid[c])
            exp_q[c].push_back(c == 0 ? (in_data[c] & EMASK) : in_data[c]);
        end
      end
      prev_rst = rst;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW-1:0] rand_word();
    logic [191:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[NW-1:0];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    flush = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_cnt[0] = '0;
    m_cnt[1] = '0;
    rst = 1'b1;
    ap_start = 1'b0;
    flush = 1'b0;
    in_valid = '0;
    out_ready = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // First word: one-cycle latency, counted one cycle after the pop.
    ap_start = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0] = NW'(1);
    out_ready[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("pin_first_valid", NW'(act_vld[0]), NW'(1));
    check("pin_first_data", act_data[0], NW'(1));
    tick();
    @(negedge clk);
    check("pin_first_cnt", NW'(act_cnt[0]), NW'(1));

    // Fill east to full with the output stalled; fifth word held off.
    do_reset();
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1;
      in_data[0] = NW'(16 + i);
      tick();
    end
    in_data[0] = NW'(20);
    @(negedge clk);
    check("pin_full_level", NW'(act_lvl[0]), NW'(4));
    check("pin_full_ready", NW'(act_rdy[0]), NW'(0));
    tick();
    tick();
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("pin_full_head", act_data[0], NW'(16));
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    check("pin_full_drained", NW'(act_lvl[0]), NW'(0));

    // ap_start low: north stops accepting but keeps draining.
    do_reset();
    out_ready[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[1] = 1'b1;
      in_data[1] = rand_word();
      tick();
    end
    ap_start = 1'b0;
    in_data[1] = rand_word();
    out_ready[1] = 1'b1;
    @(negedge clk);
    check("pin_apstart_ready", NW'(act_rdy[1]), NW'(0));
    tick();
    tick();
    @(negedge clk);
    check("pin_apstart_level", NW'(act_lvl[1]), NW'(0));
    in_valid[1] = 1'b0;
    ap_start = 1'b1;

    // Level 2, simultaneous push and pop for 10 cycles.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid[0] = 1'b1;
      in_data[0] = rand_word();
      tick();
    end
    out_ready[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data[0] = rand_word();
      tick();
    end
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("pin_steady_level", NW'(act_lvl[0]), NW'(2));
    check("pin_steady_cnt", NW'(act_cnt[0]), NW'(10));
    tick();
    tick();

    // Flush with three words on each channel; east pops in the flush cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 2'b11;
      in_data[0] = rand_word();
      in_data[1] = rand_word();
      tick();
    end
    in_valid = '0;
    flush = 1'b1;
    out_ready[0] = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = '0;
    @(negedge clk);
    check("pin_flush_e_level", NW'(act_lvl[0]), NW'(0));
    check("pin_flush_e_valid", NW'(act_vld[0]), NW'(0));
    check("pin_flush_n_level", NW'(act_lvl[1]), NW'(0));
    check("pin_flush_n_valid", NW'(act_vld[1]), NW'(0));
    check("pin_flush_e_cnt", NW'(act_cnt[0]), NW'(1));
    check("pin_flush_n_cnt", NW'(act_cnt[1]), NW'(0));

    // 17 transfers through a 4-bit counter, then reset mid-stream.
    do_reset();
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 18; i++) begin
      in_data[0] = rand_word();
      tick();
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    @(negedge clk);
    check("pin_wrap_cnt", NW'(act_cnt[0]), NW'(1));
    check("pin_wrap_level", NW'(act_lvl[0]), NW'(1));
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    in_data[0] = rand_word();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    @(negedge clk);
    check("pin_rst_level", NW'(act_lvl[0]), NW'(0));
    check("pin_rst_valid", NW'(act_vld[0]), NW'(0));
    check("pin_rst_cnt", NW'(act_cnt[0]), NW'(0));
    check("pin_rst_data", act_data[0], NW'(0));
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 31) == 0);
      ap_start = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < 2; c++) begin
        in_valid[c]  = ($urandom_range(0, 3) != 0);
        out_ready[c] = ($urandom_range(0, 2) != 0);
        in_data[c]   = rand_word();
      end
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = '0;
    out_ready = '0;
    tick();
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pe_relay_fifo.md
PE_RELAY_FIFO -- requirements
Module: pe_relay_fifo

Interface
REQ-001 SHALL have parameter EAST_WIDTH, default 130, east channel data width.
REQ-002 SHALL have parameter NORTH_WIDTH, default 164, north channel data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per channel; power of two, >=2.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, transfer-counter width.
REQ-005 SHALL have ports, clock and reset first: clk in 1 clock; reset in 1, synchronous, active-high.
REQ-006 SHALL have ports ap_start in 1 (accept enable) and flush in 1 (synchronous FIFO clear).
REQ-007 SHALL have east input ports: in_from_east in EAST_WIDTH; in_east_valid in 1; in_east_ready out 1.
REQ-008 SHALL have east output ports: out_to_east out EAST_WIDTH; out_east_valid out 1; out_east_ready in 1.
REQ-009 SHALL have north ports mirroring REQ-007/008, named *_north, width NORTH_WIDTH.
REQ-010 SHALL have status ports east_level and north_level, out, clog2(FIFO_DEPTH+1) bits each, current occupancy.
REQ-011 SHALL have status ports east_xfer_cnt and north_xfer_cnt, out, CNT_WIDTH bits each, count of output transfers.

Function
REQ-012 Channels SHALL be fully independent; east and north behaviour identical except width.
REQ-013 Push SHALL occur when in_*_valid && in_*_ready; in_*_ready = ap_start && !full && !flush.
REQ-014 Pop SHALL occur when out_*_valid && out_*_ready; out_*_valid = !empty, independent of ap_start.
REQ-015 ap_start low SHALL block pushes only; stored words keep draining.
REQ-016 Latency SHALL be 1 cycle: word pushed in cycle N appears on out_to_* with valid in cycle N+1 if the FIFO was empty.
REQ-017 out_to_* SHALL always show the head entry; it SHALL stay stable while out_*_valid && !out_*_ready.
REQ-018 Simultaneous push and pop on a non-empty FIFO SHALL leave level unchanged and preserve order.
REQ-019 Full FIFO SHALL deassert in_*_ready even if a pop occurs in that cycle; no same-cycle full bypass.
REQ-020 Read/write pointers SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-021 level SHALL increment on push only, decrement on pop only, never exceed FIFO_DEPTH or go below 0.
REQ-022 xfer_cnt SHALL increment by 1 on each pop and wrap from 2^CNT_WIDTH-1 to 0.
REQ-023 flush SHALL, next cycle, empty both FIFOs (level 0, out_*_valid 0); any pop in the flush cycle still counts in xfer_cnt.
REQ-024 flush SHALL NOT clear xfer_cnt.

Reset
REQ-025 reset SHALL take priority over flush, push and pop.
REQ-026 On reset: pointers 0, level 0, out_*_valid 0, out_to_* 0, xfer_cnt 0, in_*_ready 0 during the reset cycle.
REQ-027 Reset asserted mid-transfer SHALL discard all stored words; no output transfer occurs in the reset cycle.

Structure
REQ-028 Default widths, FIFO_DEPTH and CNT_WIDTH defaults SHALL live in shared package pe_relay_pkg.
REQ-029 One sub-module pe_relay_chan (parametrised width/depth FIFO plus level/xfer counter) SHALL be instantiated once per channel.
REQ-030 Storage SHALL be register-based; no BRAM inference.

Verification
REQ-031 Reset, then push east 0x1 in cycle 1 with out_east_ready=1 -> out_east_valid=1, out_to_east=0x1 in cycle 2; east_xfer_cnt=1 in cycle 3.
REQ-032 out_east_ready=0, push 0x10..0x13 -> east_level=4, in_east_ready=0; fifth word held off; release ready -> 0x10..0x13 in order.
REQ-033 ap_start=0 with 2 words stored, out_north_ready=1 -> in_north_ready=0, both words drain, north_level reaches 0.
REQ-034 Level 2, simultaneous push and pop for 10 cycles -> level stays 2, 10 words out in order, pointers wrap cleanly.
REQ-035 3 words stored, flush=1 for 1 cycle -> level 0 and out_*_valid 0 next cycle; xfer_cnt unchanged except a flush-cycle pop.
REQ-036 CNT_WIDTH=4, 17 transfers -> xfer_cnt sequence wraps 15 -> 0, final value 1; reset mid-stream -> all outputs 0 next cycle.
